// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: sequential issue/writeback controller in front of a combinational ALU.
// Accepts one instruction per IDLE cycle (valid/ready). Operands come from a 16-entry
// register file, with R0 hard-wired to zero. The controller drives the ALU inputs,
// captures the ALU result and writes it back to the register file or to the PC.
// Each instruction takes three cycles: IDLE -> EXEC -> WB.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   instr_valid/ready instruction handshake
//   instr[31:0]       [31:28] op, [27:24] rd, [23:20] ra, [19:16] rb, [15] use_imm, [14:0] imm
//   alu_op/a/b/pc     registered ALU inputs; alu_pc is the current PC + 1
//   alu_r             ALU result (combinational, from the ALU)
//   pc                architectural program counter
//   busy              high whenever the controller is not in IDLE
//   illegal           one-cycle pulse while an op 14/15 retires
//
// Optional feature ALU_ISSUE_TRACE_EN adds the retire trace outputs
// retire_valid, retire_rd, retire_data and retire_pc. They are valid during WB.
module alu_issue_ctrl #(
  parameter int unsigned bit_width  = 32,
  parameter int unsigned NREGS_LOG2 = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [31:0]          instr,
  output logic [3:0]           alu_op,
  output logic [bit_width-1:0] alu_a,
  output logic [bit_width-1:0] alu_b,
  output logic [bit_width-1:0] alu_pc,
  input  logic [bit_width-1:0] alu_r,
  output logic [bit_width-1:0] pc,
  output logic                 busy,
  output logic                 illegal
`ifdef ALU_ISSUE_TRACE_EN
  ,
  output logic                 retire_valid,
  output logic [3:0]           retire_rd,
  output logic [bit_width-1:0] retire_data,
  output logic [bit_width-1:0] retire_pc
`endif
);

  localparam int unsigned NREGS = 2 ** NREGS_LOG2;
  localparam int unsigned IMM_W = 15;

  typedef struct packed {
    logic [3:0]       op;
    logic [3:0]       rd;
    logic [3:0]       ra;
    logic [3:0]       rb;
    logic             use_imm;
    logic [IMM_W-1:0] imm;
  } instr_t;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  state_t               state_q, state_d;
  instr_t               dec;
  logic                 accept_c;
  logic [3:0]           op_q, rd_q;
  logic [bit_width-1:0] result_q;
  logic [bit_width-1:0] regs [NREGS];
  logic [bit_width-1:0] rd_a_c, rd_b_c;
  logic [bit_width-1:0] pc_inc_c;

  assign dec      = instr_t'(instr);
  assign pc_inc_c = pc + bit_width'(1);

  // Register 0 always reads as zero.
  assign rd_a_c = (dec.ra == 4'd0) ? '0 : regs[dec.ra];
  assign rd_b_c = (dec.rb == 4'd0) ? '0 : regs[dec.rb];

  // Compute the next state. An instruction is accepted only in IDLE.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (instr_valid && instr_ready) begin
          accept_c = 1'b1;
          state_d  = S_EXEC;
        end
      end
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      rd_q        <= '0;
      result_q    <= '0;
      pc          <= '0;
      alu_op      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_pc      <= '0;
      instr_ready <= 1'b1;
      busy        <= 1'b0;
      illegal     <= 1'b0;
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
`ifdef ALU_ISSUE_TRACE_EN
      retire_valid <= 1'b0;
      retire_rd    <= '0;
      retire_data  <= '0;
      retire_pc    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      instr_ready <= (state_d == S_IDLE);
      busy        <= (state_d != S_IDLE);
      illegal     <= 1'b0;
`ifdef ALU_ISSUE_TRACE_EN
      retire_valid <= 1'b0;
      retire_rd    <= '0;
      retire_data  <= '0;
      retire_pc    <= '0;
`endif
      case (state_q)
        S_IDLE: begin
          if (accept_c) begin
            op_q   <= dec.op;
            rd_q   <= dec.rd;
            alu_op <= dec.op;
            alu_a  <= rd_a_c;
            alu_b  <= dec.use_imm ? bit_width'(dec.imm) : rd_b_c;
            alu_pc <= pc_inc_c;
          end
        end
        S_EXEC: begin
          result_q <= alu_r;
          // WB-cycle flags are registered here so that they line up with WB.
          illegal  <= (op_q[3:1] == 3'b111);
`ifdef ALU_ISSUE_TRACE_EN
          retire_valid <= 1'b1;
          retire_rd    <= (op_q >= 4'd12) ? 4'hF : rd_q;
          retire_data  <= alu_r;
          retire_pc    <= (op_q == 4'd12 || op_q == 4'd13) ? alu_r : pc_inc_c;
`endif
        end
        S_WB: begin
          if (op_q <= 4'd11) begin
            if (rd_q != 4'd0) regs[rd_q] <= result_q;
            pc <= pc_inc_c;
          end else if (op_q <= 4'd13) begin
            pc <= result_q;
          end else begin
            pc <= pc_inc_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
